store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- 4-entry in-order write buffer between the EX/MEM pipeline register and the data memory.
- Accepts sw/sb/sh from the MEM stage in one cycle and drains them to the data memory on cycles with no load.
- Checks every load against pending stores: forwards an exact word match, otherwise stalls the load until the conflicting store has drained.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, >=2)
- ADDR_W, 32, byte-address width
- DATA_W, 32, store data width

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_size  in  2  01=sw, 10=sb, 11=sh (same encoding as data-memory memwrite); 00 invalid
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data; sb uses [7:0], sh uses [15:0]
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  load in MEM stage this cycle
- ld_size  in  2  01=lw, 10=lb, 11=lh
- ld_addr  in  ADDR_W  load byte address
- ld_hit  out  1  load served from buffer
- ld_hit_data  out  DATA_W  forwarded word
- ld_stall  out  1  hold pipeline; load conflicts with a pending store
- mem_write  out  2  to data-memory memwrite; 00 = no write
- mem_addr  out  ADDR_W  to data-memory address
- mem_wdata  out  DATA_W  to data-memory write data
- misalign_err  out  1  one-cycle pulse: store rejected
- count  out  log2(DEPTH)+1  valid entries
- empty  out  1  count==0 and no drain in flight

Behaviour:
- Reset (sync, dominates everything):
  - all entries invalid; count=0; head/tail pointers=0
  - mem_write=00, mem_addr=0, mem_wdata=0, misalign_err=0
  - pending stores are discarded, including one captured in the same cycle
- Storage: circular FIFO with head (oldest) and tail pointers; wrap modulo DEPTH. Entry = {size, addr, data}.
- st_ready = (count != DEPTH). It is combinational from registered count and does not depend on a same-cycle drain.
- Enqueue on posedge when st_valid && st_ready && st_size != 00 && aligned.
  - Alignment: sw needs addr[1:0]==00; sh needs addr[0]==0; sb is always aligned.
  - Misaligned or size 00: nothing is enqueued; misalign_err=1 for the next cycle.
- Drain condition at posedge: count>0 && (!ld_valid || ld_stall).
  - Loads take priority; a stalled load never blocks draining, which prevents deadlock.
  - On drain: mem_write/mem_addr/mem_wdata are registered from the head entry, and head advances.
  - Otherwise mem_write<=00.
  - Each drained write is visible on mem_* for exactly one cycle; the data memory commits it on that cycle's negedge.
- Latency: a store accepted at edge N drives mem_write in the cycle after edge N+1 at the earliest. There is no bypass when the buffer is empty.
- Count update:
  - enqueue only: +1
  - drain only: -1
  - both: unchanged
  - full+drain: st_ready is still 0 that cycle
- Hazard check is combinational, on ld_valid. It compares word address ld_addr[31:2] against all valid entries plus the in-flight mem_* register when mem_write!=00.
  - No match: ld_hit=0, ld_stall=0.
  - The youngest match is an entry with size 01, ld_size=01, and the addresses are exactly equal: ld_hit=1, ld_hit_data=entry data, ld_stall=0. Older matches are ignored.
  - Any other match (partial, byte/half, or the in-flight write): ld_stall=1, ld_hit=0.
- When ld_valid=0: ld_hit=0, ld_stall=0, ld_hit_data=0.
- empty = (count==0) && (mem_write==00).

Test Plan:
- Reset, then sw addr=0x10 data=0xDEADBEEF with ld_valid=0:
  - count=1 after the edge
  - next cycle: mem_write=01, mem_addr=0x10, mem_wdata=0xDEADBEEF
  - then count=0 and empty=1
- With ld_valid=1 held to an unrelated address (0x40), enqueue 4 sw (addr 0x0,0x4,0x8,0xC):
  - count=4, st_ready=0; a 5th st_valid is not accepted
  - drop ld_valid: drains in order 0x0,0x4,0x8,0xC on 4 consecutive cycles
- sw 0x20=0x11111111 then sw 0x20=0x22222222 buffered, then lw 0x20: ld_hit=1, ld_hit_data=0x22222222, ld_stall=0.
- sb 0x23=0xAB buffered, then lb 0x23: ld_stall=1 until the sb has drained and mem_write returns to 00, then ld_stall=0, ld_hit=0.
- sw to 0x22: rejected, misalign_err=1 for one cycle, count unchanged. sh to 0x21 behaves the same. sh to 0x22 is accepted.
- Assert reset with count=3 and a drain in flight: next cycle count=0, mem_write=00, empty=1; no further memory writes occur.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : In-order write buffer that sits between the EX/MEM pipeline
//               register and the data memory. Stores (sw/sb/sh) are accepted
//               in one cycle and drained to memory on cycles without a load.
//               Every load is checked against the pending stores: an exact
//               word match is forwarded, and any other overlap stalls the load
//               until the conflicting store has drained.
// Ports       :
//   clk, reset                    clock, synchronous active-high reset
//   st_valid/st_size/st_addr/
//   st_data -> st_ready           store request from MEM stage, accept flag
//   ld_valid/ld_size/ld_addr ->
//   ld_hit/ld_hit_data/ld_stall   load hazard check and forwarding
//   mem_write/mem_addr/mem_wdata  registered write port to data memory
//   misalign_err                  one-cycle pulse when a store is rejected
//   count, empty                  occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [1:0]               st_size,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [1:0]               ld_size,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_hit_data,
  output logic                     ld_stall,
  output logic [1:0]               mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] c_SZ_NONE = 2'b00;
  localparam logic [1:0] c_SZ_WORD = 2'b01;
  localparam logic [1:0] c_SZ_BYTE = 2'b10;
  localparam logic [1:0] c_SZ_HALF = 2'b11;

  // Entry storage; validity is implied by head/count, so no per-entry flag.
  logic [1:0]        r_size [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_misalign;

  logic              w_aligned;
  logic              w_enq;
  logic              w_drain;
  logic [PTR_W-1:0]  w_idx;
  logic              w_ent_match;
  logic              w_y_exact;
  logic [DATA_W-1:0] w_y_data;
  logic              w_fly_match;

  // --------------------------------------------------------------------------
  // Store acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    w_aligned = 1'b0;
    case (st_size)
      c_SZ_WORD: w_aligned = (st_addr[1:0] == 2'b00);
      c_SZ_HALF: w_aligned = (st_addr[0] == 1'b0);
      c_SZ_BYTE: w_aligned = 1'b1;
      default:   w_aligned = 1'b0;  // size 00 is never a legal store
    endcase
  end

  assign st_ready = (r_count != CNT_W'(DEPTH));
  assign w_enq    = st_valid && st_ready && w_aligned;

  // --------------------------------------------------------------------------
  // Load hazard check: walk entries oldest to youngest so the last match
  // found is the youngest one, which alone decides hit vs stall.
  // --------------------------------------------------------------------------
  always_comb begin
    w_idx       = '0;
    w_ent_match = 1'b0;
    w_y_exact   = 1'b0;
    w_y_data    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) &&
          (r_addr[w_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        w_ent_match = 1'b1;
        w_y_exact   = (r_size[w_idx] == c_SZ_WORD) && (ld_size == c_SZ_WORD) &&
                      (r_addr[w_idx] == ld_addr);
        w_y_data    = r_data[w_idx];
      end
    end
  end

  // The write on mem_* is older than every buffered entry, so it only matters
  // when no buffered entry matched; it cannot be forwarded.
  assign w_fly_match = (r_mem_write != c_SZ_NONE) &&
                       (r_mem_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);

  assign ld_hit      = ld_valid && w_ent_match && w_y_exact;
  assign ld_stall    = ld_valid && ((w_ent_match && !w_y_exact) ||
                                    (!w_ent_match && w_fly_match));
  assign ld_hit_data = ld_hit ? w_y_data : '0;

  // A stalled load must not block draining, otherwise it would wait forever.
  assign w_drain = (r_count != '0) && (!ld_valid || ld_stall);

  // --------------------------------------------------------------------------
  // Entry storage (not reset: contents are meaningless while count is zero)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_size[r_tail] <= st_size;
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and memory write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_mem_write <= c_SZ_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= st_valid && !w_aligned;

      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end

      if (w_drain) begin
        r_mem_write <= r_size[r_head];
        r_mem_addr  <= r_addr[r_head];
        r_mem_wdata <= r_data[r_head];
        r_head      <= r_head + 1'b1;
      end else begin
        r_mem_write <= c_SZ_NONE;
      end

      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_write    = r_mem_write;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign misalign_err = r_misalign;
  assign count        = r_count;
  assign empty        = (r_count == '0) && (r_mem_write == c_SZ_NONE);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue-based reference
//               model predicts every output each cycle; directed sequences
//               exercise the listed scenarios and a random phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [1:0]  ld_size;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_hit_data;
  logic        ld_stall;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        misalign_err;
  logic [2:0]  count;
  logic        empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_size(ld_size), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_hit_data(ld_hit_data), .ld_stall(ld_stall),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .misalign_err(misalign_err), .count(count), .empty(empty)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  m_mw;
  logic [31:0] m_ma;
  logic [31:0] m_md;
  logic        m_err;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b01 && a[1:0] == 2'b00) || (sz == 2'b11 && a[0] == 1'b0) ||
           (sz == 2'b10);
  endfunction

  // One cycle: drive at negedge, check outputs, advance the model to the
  // state the coming posedge should produce.
  task automatic step(input logic rst, input logic sv, input logic [1:0] ssz,
                      input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [1:0] lsz, input logic [31:0] la);
    logic e_hit, e_stall, e_ready, e_drain, found;
    logic [31:0] e_data;
    ent_t head;
    @(negedge clk);
    reset = rst; st_valid = sv; st_size = ssz; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_size = lsz; ld_addr = la;
    #1;
    e_ready = (mq.size() != DEPTH);
    e_hit = 1'b0; e_stall = 1'b0; e_data = 32'h0; found = 1'b0;
    if (lv) begin
      for (int i = mq.size() - 1; i >= 0 && !found; i--) begin
        if (mq[i].addr[31:2] == la[31:2]) begin
          found = 1'b1;
          if (mq[i].size == 2'b01 && lsz == 2'b01 && mq[i].addr == la) begin
            e_hit = 1'b1; e_data = mq[i].data;
          end else begin
            e_stall = 1'b1;
          end
        end
      end
      if (!found && m_mw != 2'b00 && m_ma[31:2] == la[31:2]) e_stall = 1'b1;
    end
    check("st_ready", st_ready, e_ready);
    check("count", count, mq.size());
    check("empty", empty, (mq.size() == 0) && (m_mw == 2'b00));
    check("mem_write", mem_write, m_mw);
    if (m_mw != 2'b00) begin
      check("mem_addr", mem_addr, m_ma);
      check("mem_wdata", mem_wdata, m_md);
    end
    check("misalign_err", misalign_err, m_err);
    check("ld_hit", ld_hit, e_hit);
    check("ld_stall", ld_stall, e_stall);
    if (e_hit || !lv) check("ld_hit_data", ld_hit_data, e_data);

    e_drain = (mq.size() > 0) && (!lv || e_stall);
    if (rst) begin
      mq.delete(); m_mw = 2'b00; m_ma = 32'h0; m_md = 32'h0; m_err = 1'b0;
    end else begin
      if (e_drain) begin
        head = mq.pop_front();
        m_mw = head.size; m_ma = head.addr; m_md = head.data;
      end else begin
        m_mw = 2'b00;
      end
      if (sv && e_ready && legal(ssz, sa)) mq.push_back('{ssz, sa, sd});
      m_err = sv && !legal(ssz, sa);
    end
  endtask

  task automatic idle(input logic lv, input logic [31:0] la);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, lv, 2'b01, la);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input logic lv);
    step(1'b0, 1'b1, sz, a, d, lv, 2'b01, 32'h40);
  endtask

  // Observe registered state just after the edge closing the last step.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic cleared;
    reset = 1'b1; st_valid = 1'b0; st_size = 2'b00; st_addr = 32'h0; st_data = 32'h0;
    ld_valid = 1'b0; ld_size = 2'b00; ld_addr = 32'h0;
    m_mw = 2'b00; m_ma = 32'h0; m_md = 32'h0; m_err = 1'b0;
    repeat (3) @(posedge clk);

    // Single sw, no load: enqueue, drain next edge, then empty.
    store(2'b01, 32'h10, 32'hDEADBEEF, 1'b0);
    after_edge();
    check("t1_count_after_enq", count, 1);
    idle(1'b0, 32'h0);
    after_edge();
    check("t1_mem_write", mem_write, 2'b01);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    idle(1'b0, 32'h0);
    after_edge();
    check("t1_count_zero", count, 0);
    check("t1_empty", empty, 1'b1);

    // Fill while an unrelated load holds off draining; then drain in order.
    for (int i = 0; i < 4; i++) store(2'b01, 32'(i * 4), 32'hA0 + 32'(i), 1'b1);
    store(2'b01, 32'h30, 32'h55, 1'b1);
    check("t2_ready_full", st_ready, 1'b0);
    after_edge();
    check("t2_count_full", count, 4);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 32'h0);
      after_edge();
      check("t2_drain_addr", mem_addr, 32'(i * 4));
      check("t2_drain_write", mem_write, 2'b01);
    end
    idle(1'b0, 32'h0);

    // Youngest exact sw forwards.
    store(2'b01, 32'h20, 32'h11111111, 1'b1);
    store(2'b01, 32'h20, 32'h22222222, 1'b1);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b01, 32'h20);
    check("t3_hit", ld_hit, 1'b1);
    check("t3_hit_data", ld_hit_data, 32'h22222222);
    check("t3_stall", ld_stall, 1'b0);
    repeat (4) idle(1'b0, 32'h0);

    // Byte store blocks a byte load until fully written.
    store(2'b10, 32'h23, 32'hAB, 1'b1);
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b10, 32'h23);
    check("t4_stall_first", ld_stall, 1'b1);
    cleared = 1'b0;
    for (int i = 0; i < 10 && !cleared; i++) begin
      step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b10, 32'h23);
      if (!ld_stall) cleared = 1'b1;
    end
    check("t4_stall_cleared", cleared, 1'b1);
    check("t4_no_hit", ld_hit, 1'b0);
    check("t4_mem_idle", mem_write, 2'b00);

    // Misaligned stores are rejected with a one-cycle error pulse.
    store(2'b01, 32'h22, 32'h1, 1'b0);
    after_edge();
    check("t5_sw_err", misalign_err, 1'b1);
    check("t5_sw_count", count, 0);
    idle(1'b0, 32'h0);
    after_edge();
    check("t5_err_clear", misalign_err, 1'b0);
    store(2'b11, 32'h21, 32'h2, 1'b0);
    after_edge();
    check("t5_sh_err", misalign_err, 1'b1);
    check("t5_sh_count", count, 0);
    store(2'b11, 32'h22, 32'h3, 1'b0);
    after_edge();
    check("t5_sh_ok_err", misalign_err, 1'b0);
    check("t5_sh_ok_count", count, 1);
    repeat (3) idle(1'b0, 32'h0);

    // Reset with three entries pending and a drain in flight.
    for (int i = 0; i < 4; i++) store(2'b01, 32'h100 + 32'(i * 4), 32'(i), 1'b1);
    idle(1'b0, 32'h0);
    after_edge();
    check("t6_count3", count, 3);
    check("t6_inflight", mem_write, 2'b01);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b01, 32'h0);
    after_edge();
    check("t6_rst_count", count, 0);
    check("t6_rst_write", mem_write, 2'b00);
    check("t6_rst_empty", empty, 1'b1);
    repeat (4) idle(1'b0, 32'h0);

    // Random traffic over a small address window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 60),
           2'($urandom_range(0, 3)),
           32'($urandom_range(0, 47)),
           $urandom(),
           ($urandom_range(0, 99) < 45),
           2'($urandom_range(1, 3)),
           32'($urandom_range(0, 47)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
